// File: rtl/lock_key_loader_if.sv
// Key-delivery bus between the key source and lock_key_loader.
// The master drives the serial key and controls; the slave returns the applied key and status.
interface lock_key_loader_if #(
    parameter int KEY_W = 2
);
    logic             sdi;
    logic             sdi_vld;
    logic             par_in;
    logic             commit;
    logic             clear;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             busy;
    logic             err;
    logic             lockout;

    modport master (
        output sdi, sdi_vld, par_in, commit, clear,
        input  key_out, key_valid, busy, err, lockout
    );

    modport slave (
        input  sdi, sdi_vld, par_in, commit, clear,
        output key_out, key_valid, busy, err, lockout
    );
endinterface

// File: rtl/lock_key_loader.sv
// Serial key loader for the XOR-locked c17 netlist: shifts in the key, checks count and
// even parity, applies it on a valid commit, and locks out permanently after MAX_FAIL bad commits.
module lock_key_loader #(
    parameter int KEY_W    = 2,
    parameter int MAX_FAIL = 3
) (
    input  logic              clk,
    input  logic              rst,
    lock_key_loader_if.slave  bus
);
    localparam int             CW       = $clog2(KEY_W + 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(KEY_W);
    localparam logic [3:0]     FAIL_MAX = 4'(MAX_FAIL);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_FULL    = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_ERROR   = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [KEY_W-1:0]  shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        fail_q, fail_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              key_valid_q, key_valid_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              lockout_q, lockout_d;
    logic              fail_commit_s;
    logic [3:0]        fail_inc_s;

    function automatic logic key_parity(input logic [KEY_W-1:0] v);
        return ^v;
    endfunction

    // Next-state logic; branch order encodes the priority LOCKOUT > clear > commit > sdi_vld.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        fail_d        = fail_q;
        key_d         = key_q;
        key_valid_d   = key_valid_q;
        fail_commit_s = 1'b0;
        fail_inc_s    = (fail_q == 4'hF) ? 4'hF : fail_q + 4'd1;

        if (state_q == ST_LOCKOUT) begin
            key_d       = '0;
            key_valid_d = 1'b0;
        end else if (bus.clear) begin
            state_d     = ST_IDLE;
            shift_d     = '0;
            cnt_d       = '0;
            key_d       = '0;
            key_valid_d = 1'b0;
        end else if (bus.commit) begin
            // A commit in the same cycle as sdi_vld wins; the serial bit is dropped.
            case (state_q)
                ST_IDLE, ST_SHIFT: fail_commit_s = 1'b1;
                ST_FULL: begin
                    if (key_parity(shift_q) == bus.par_in) begin
                        state_d     = ST_LOCKED;
                        key_d       = shift_q;
                        key_valid_d = 1'b1;
                    end else begin
                        fail_commit_s = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else if (bus.sdi_vld) begin
            case (state_q)
                ST_IDLE, ST_SHIFT: begin
                    shift_d = shift_q | (KEY_W'(bus.sdi) << cnt_q);
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_d == CNT_FULL) ? ST_FULL : ST_SHIFT;
                end
                ST_FULL: state_d = ST_ERROR;
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (fail_commit_s) begin
            fail_d  = fail_inc_s;
            state_d = (fail_inc_s == FAIL_MAX) ? ST_LOCKOUT : ST_ERROR;
        end else begin
            fail_d = fail_d;
        end

        busy_d    = (state_d == ST_SHIFT) || (state_d == ST_FULL);
        err_d     = (state_d == ST_ERROR) || (state_d == ST_LOCKOUT);
        lockout_d = (state_d == ST_LOCKOUT);
    end

    // State and registered outputs; rst zeroizes everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            fail_q      <= 4'd0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            lockout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            fail_q      <= fail_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            lockout_q   <= lockout_d;
        end
    end

    assign bus.key_out   = key_q;
    assign bus.key_valid = key_valid_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.lockout   = lockout_q;
endmodule

// File: tb/tb_lock_key_loader.sv
// Scoreboard bench for lock_key_loader: a behavioural model predicts every cycle's outputs,
// directed sequences cover the key-load scenarios, then a short random run follows.
module tb_lock_key_loader;
    localparam int M_IDLE = 0, M_SHIFT = 1, M_FULL = 2, M_LOCKED = 3, M_ERROR = 4, M_LOCKOUT = 5;
    localparam int MAXF = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    lock_key_loader_if #(.KEY_W(2)) bus ();
    lock_key_loader #(.KEY_W(2), .MAX_FAIL(MAXF)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [5:0] v;
    } exp_t;
    exp_t sbq[$];

    int         m_st;
    int         m_cnt;
    int         m_fail;
    logic [1:0] m_sh;
    logic [1:0] m_key;
    logic       m_kv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] dut_vec();
        return {bus.key_out, bus.key_valid, bus.busy, bus.err, bus.lockout};
    endfunction

    function automatic logic [5:0] model_vec();
        return {m_key, m_kv, (m_st == M_SHIFT) || (m_st == M_FULL),
                (m_st == M_ERROR) || (m_st == M_LOCKOUT), m_st == M_LOCKOUT};
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_cnt = 0; m_fail = 0; m_sh = 2'b00; m_key = 2'b00; m_kv = 1'b0;
    endtask

    task automatic model_fail();
        if (m_fail < 15) m_fail++;
        m_st = (m_fail == MAXF) ? M_LOCKOUT : M_ERROR;
    endtask

    task automatic model_step(input logic s, input logic v, input logic p, input logic cm, input logic cl);
        if (m_st == M_LOCKOUT) begin
            m_key = 2'b00;
        end else if (cl) begin
            m_st = M_IDLE; m_cnt = 0; m_sh = 2'b00; m_key = 2'b00; m_kv = 1'b0;
        end else if (cm) begin
            if (m_st == M_FULL && ((m_sh[0] ^ m_sh[1] ^ p) == 1'b0)) begin
                m_st = M_LOCKED; m_key = m_sh; m_kv = 1'b1;
            end else if (m_st == M_IDLE || m_st == M_SHIFT || m_st == M_FULL) begin
                model_fail();
            end
        end else if (v) begin
            if (m_st == M_IDLE || m_st == M_SHIFT) begin
                m_sh[m_cnt] = s;
                m_cnt++;
                m_st = (m_cnt == 2) ? M_FULL : M_SHIFT;
            end else if (m_st == M_FULL) begin
                m_st = M_ERROR;
            end
        end
    endtask

    task automatic cyc(input string tag, input logic s, input logic v, input logic p,
                       input logic cm, input logic cl);
        exp_t e;
        bus.sdi = s; bus.sdi_vld = v; bus.par_in = p; bus.commit = cm; bus.clear = cl;
        model_step(s, v, p, cm, cl);
        e.tag = tag;
        e.v   = model_vec();
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk(e.tag, {26'd0, dut_vec()}, {26'd0, e.v});
        bus.sdi = 1'b0; bus.sdi_vld = 1'b0; bus.par_in = 1'b0; bus.commit = 1'b0; bus.clear = 1'b0;
    endtask

    task automatic shift_bit(input logic b);
        cyc("shift", b, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_key(input logic b0, input logic b1, input logic p);
        shift_bit(b0);
        shift_bit(b1);
        cyc("commit", 1'b0, 1'b0, p, 1'b1, 1'b0);
    endtask

    task automatic clr();
        cyc("clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Asserts rst mid-cycle and checks that outputs drop before any clock edge.
    task automatic do_rst();
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async", {26'd0, dut_vec()}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bus.sdi = 1'b0; bus.sdi_vld = 1'b0; bus.par_in = 1'b0; bus.commit = 1'b0; bus.clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {26'd0, dut_vec()}, 32'd0);
        rst = 1'b0;

        load_key(1'b1, 1'b0, 1'b1);
        chk("key01", {30'd0, bus.key_out}, 32'd1);
        chk("key01_valid", {31'd0, bus.key_valid}, 32'd1);
        chk("key01_busy", {31'd0, bus.busy}, 32'd0);
        clr();

        load_key(1'b1, 1'b1, 1'b1);
        chk("par_bad_err", {31'd0, bus.err}, 32'd1);
        chk("par_bad_key", {30'd0, bus.key_out}, 32'd0);
        clr();
        chk("clear_err", {31'd0, bus.err}, 32'd0);
        load_key(1'b1, 1'b1, 1'b0);
        chk("key11", {30'd0, bus.key_out}, 32'd3);
        clr();

        do_rst();
        shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1);
        chk("overflow_err", {31'd0, bus.err}, 32'd1);
        clr();
        shift_bit(1'b1);
        cyc("early_commit", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        clr();
        load_key(1'b0, 1'b0, 1'b1);
        chk("fail2_no_lock", {31'd0, bus.lockout}, 32'd0);
        clr();
        load_key(1'b0, 1'b0, 1'b1);
        chk("fail3_lock", {31'd0, bus.lockout}, 32'd1);

        do_rst();
        for (int i = 0; i < 3; i++) begin
            load_key(1'b1, 1'b1, 1'b1);
            chk("lockout_cnt", {31'd0, bus.lockout}, (i == 2) ? 32'd1 : 32'd0);
            clr();
        end
        load_key(1'b1, 1'b0, 1'b1);
        chk("lockout_key", {30'd0, bus.key_out}, 32'd0);
        chk("lockout_hold", {31'd0, bus.lockout}, 32'd1);
        do_rst();

        load_key(1'b0, 1'b1, 1'b1);
        chk("key10", {30'd0, bus.key_out}, 32'd2);
        cyc("locked_ign", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("locked_ign_v", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("locked_ign_c", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("key10_held", {30'd0, bus.key_out}, 32'd2);
        clr();
        chk("clear_key", {29'd0, bus.key_out, bus.key_valid}, 32'd0);

        shift_bit(1'b1);
        do_rst();
        load_key(1'b1, 1'b0, 1'b1);
        do_rst();
        shift_bit(1'b1); shift_bit(1'b0);
        cyc("full_clr_cm", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("full_clr_cm_key", {29'd0, bus.key_out, bus.busy}, 32'd0);
        shift_bit(1'b1); shift_bit(1'b0);
        cyc("full_cm_vld", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("full_cm_vld_key", {30'd0, bus.key_out}, 32'd1);
        clr();
        shift_bit(1'b1);
        cyc("shift_cm_vld", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("shift_cm_vld_err", {31'd0, bus.err}, 32'd1);
        do_rst();

        for (int i = 0; i < 400; i++) begin
            if (i % 64 == 63) begin
                do_rst();
            end else begin
                cyc("rand", 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lock_key_loader.md
Name: lock_key_loader

Overview:
- Upstream key-delivery stage for the XOR-locked c17 netlist; its key_out bus drives the key inputs K1..Kn.
- Receives the key serially, checks bit count and even parity, and applies the key only on a valid commit.
- Holds the key outputs at all-zero until a commit succeeds.
- Counts failed commits and enters a permanent lockout after MAX_FAIL failures; only reset leaves lockout.

Parameters:
- KEY_W, 2, number of key bits; one per key gate (K1=key_out[0], K2=key_out[1]).
- MAX_FAIL, 3, failed commits that trigger lockout (1..15).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- sdi  input  1  serial key bit, LSB first.
- sdi_vld  input  1  sdi is valid this cycle.
- par_in  input  1  expected even-parity bit over the KEY_W key bits; sampled only when commit=1.
- commit  input  1  one-cycle request to apply the shifted key.
- clear  input  1  synchronous zeroize: returns to IDLE; does not reset fail count.
- key_out  output  KEY_W  applied key to the locked netlist.
- key_valid  output  1  key_out holds a committed key.
- busy  output  1  1 in SHIFT or FULL.
- err  output  1  1 in ERROR or LOCKOUT.
- lockout  output  1  1 in LOCKOUT.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; shift register, bit counter (0..KEY_W) and fail counter = 0.
  - key_out=0, key_valid=0, busy=0, err=0, lockout=0.
- States: IDLE, SHIFT, FULL, LOCKED, ERROR, LOCKOUT. All outputs are registered or decoded from state.
- Per-cycle priority: rst > LOCKOUT hold > clear > commit > sdi_vld.
- IDLE:
  - sdi_vld=1: shift in sdi at bit position cnt, cnt=1, go to SHIFT; go to FULL instead if KEY_W=1.
  - commit=1: counts as a failed commit.
- SHIFT:
  - sdi_vld=1: shift bit in, cnt+1; go to FULL when cnt reaches KEY_W.
  - commit=1 before FULL: counts as a failed commit.
- FULL:
  - sdi_vld=1 (overflow): go to ERROR; not counted as a fail.
  - commit=1 and XOR(shift_reg)^par_in=0: next cycle key_out=shift_reg, key_valid=1, state=LOCKED. Fail count is not cleared.
  - commit=1 and parity mismatch: counts as a failed commit.
- LOCKED:
  - sdi_vld and commit are ignored; key_out is held.
  - clear=1: key_out=0, key_valid=0, shift register and cnt=0, go to IDLE, all on the next edge.
- Failed commit handling:
  - fail_cnt+1 (saturating).
  - If the new count equals MAX_FAIL, go to LOCKOUT; otherwise go to ERROR.
  - key_out and key_valid remain 0.
- ERROR: only clear exits (to IDLE); all other inputs are ignored.
- LOCKOUT:
  - Terminal state; clear is ignored; key_out=0.
  - err=1, lockout=1; only rst exits.
- Latency: key_out and key_valid change exactly one clk after the accepting commit edge; clear takes effect one clk later.
- Same-cycle commit and sdi_vld: commit is evaluated and the sdi bit is dropped.
- rst asserted mid-shift or while LOCKED: immediate return to reset values; the partial key is discarded.
- key_out never shows a partial or uncommitted key; it is 0 in every state except LOCKED.

Test Plan:
- Reset, then shift bits 1,0 (key=2'b01), par_in=1, commit -> next cycle key_out=2'b01, key_valid=1, state LOCKED, busy=0.
- Shift 1,1 (key=2'b11), par_in=1 -> err=1, key_out=2'b00. Apply clear -> IDLE, err=0. Shift 1,1 with par_in=0 -> key_out=2'b11.
- Shift 3 bits with KEY_W=2 -> ERROR on the third sdi_vld, fail count unchanged. Commit after 1 bit -> ERROR, fail count=1.
- Three parity-fail commits, each followed by clear -> third fail sets lockout=1. A following clear plus a valid key+commit is ignored, key_out stays 0; only rst clears lockout.
- In LOCKED with key 2'b10, assert sdi_vld and commit -> key_out stays 2'b10. clear -> next cycle key_out=0, key_valid=0.
- Assert rst asynchronously after 1 bit and while LOCKED -> outputs are 0 immediately, before the next clk edge. Same-cycle clear+commit in FULL -> IDLE, no key applied.
